// File: rtl/unidade_controle_prova_pkg.sv
// Shared definitions for the genius-game control unit: the 4-bit state
// encoding, also used by the top level to drive the db_estado hex display.
package unidade_controle_prova_pkg;

  localparam int ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_NIVEL   = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMO_NIVEL  = 4'h7,
    FIM_ACERTOU    = 4'h8,
    FIM_ERROU      = 4'h9,
    FIM_TIMEOUT    = 4'hA
  } estado_t;

endpackage

// File: rtl/unidade_controle_prova.sv
// Control unit for the memory-sequence game. Moore FSM driving the datapath
// clear/count strobes, with conta_score gated by the comparison result, and
// a difficulty register latched only when a game is started.
module unidade_controle_prova
  import unidade_controle_prova_pkg::*;
#(
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       dificuldade_in,
  input  logic       jogada_igual_memoria,
  input  logic       endereco_igual_limite,
  input  logic       ultimo_nivel,
  input  logic       fez_jogada,
  input  logic       deu_timeout,
  output logic       zera_contador_nivel,
  output logic       zera_contador_jogada,
  output logic       zera_contador_score,
  output logic       zeraR,
  output logic       zera_timeout,
  output logic       conta_nivel,
  output logic       conta_jogada,
  output logic       conta_score,
  output logic       conta_timeout,
  output logic       registraR,
  output logic       dificuldade,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t proximo;
  logic    latch_dificuldade;

  // State register; reset returns to INICIAL from anywhere, even mid-game.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Difficulty is captured only when a game starts, so it stays fixed all game.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 dificuldade <= 1'b0;
    else if (latch_dificuldade) dificuldade <= dificuldade_in;
  end

  // Next-state logic and difficulty-latch enable.
  // NOTE: every signal gets a default before the case, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    proximo           = estado;
    latch_dificuldade = 1'b0;
    case (estado)
      INICIAL, FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (iniciar) begin
          proximo           = PREPARACAO;
          latch_dificuldade = 1'b1;
        end
      end
      PREPARACAO:     proximo = INICIA_NIVEL;
      INICIA_NIVEL:   proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A button press wins over a simultaneous timeout.
        if (fez_jogada)                      proximo = REGISTRA;
        else if (deu_timeout && TIMEOUT_EN)  proximo = FIM_TIMEOUT;
      end
      REGISTRA:       proximo = COMPARACAO;
      COMPARACAO: begin
        if (!jogada_igual_memoria)   proximo = FIM_ERROU;
        else if (endereco_igual_limite)
          proximo = ultimo_nivel ? FIM_ACERTOU : PROXIMO_NIVEL;
        else                         proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      PROXIMO_NIVEL:  proximo = INICIA_NIVEL;
      default:        proximo = INICIAL;
    endcase
  end

  // Output decoder: pure function of the state, except conta_score.
  always_comb begin
    zera_contador_nivel  = 1'b0;
    zera_contador_jogada = 1'b0;
    zera_contador_score  = 1'b0;
    zeraR                = 1'b0;
    zera_timeout         = 1'b0;
    conta_nivel          = 1'b0;
    conta_jogada         = 1'b0;
    conta_score          = 1'b0;
    conta_timeout        = 1'b0;
    registraR            = 1'b0;
    pronto               = 1'b0;
    acertou              = 1'b0;
    errou                = 1'b0;
    timeout              = 1'b0;
    case (estado)
      PREPARACAO: begin
        zera_contador_nivel  = 1'b1;
        zera_contador_jogada = 1'b1;
        zera_contador_score  = 1'b1;
        zeraR                = 1'b1;
        zera_timeout         = 1'b1;
      end
      INICIA_NIVEL: begin
        zera_contador_jogada = 1'b1;
        zeraR                = 1'b1;
        zera_timeout         = 1'b1;
      end
      ESPERA_JOGADA:  conta_timeout = 1'b1;
      REGISTRA: begin
        registraR    = 1'b1;
        zera_timeout = 1'b1;
      end
      // Score only advances on a correct play.
      COMPARACAO:     conta_score  = jogada_igual_memoria;
      PROXIMA_JOGADA: conta_jogada = 1'b1;
      PROXIMO_NIVEL:  conta_nivel  = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_prova.sv
// Self-checking bench for unidade_controle_prova. Two instances run side by
// side (timeout enabled / disabled) against a behavioural game model.
module tb_unidade_controle_prova;

  logic clock = 1'b0;
  logic reset;
  logic iniciar, dificuldade_in, jogada_igual_memoria, endereco_igual_limite;
  logic ultimo_nivel, fez_jogada, deu_timeout;

  logic zn [2], zj [2], zs [2], zr [2], zt [2];
  logic cn [2], cj [2], cs [2], ct [2], rr [2];
  logic dif [2], pr [2], ac [2], er [2], to [2];
  logic [3:0] db [2];

  int errors = 0;
  int checks = 0;

  // Model state: game phase code and latched difficulty per instance.
  int   m_st  [2];
  logic m_dif [2];

  always #5 clock = ~clock;

  unidade_controle_prova #(.TIMEOUT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade_in(dificuldade_in),
    .jogada_igual_memoria(jogada_igual_memoria), .endereco_igual_limite(endereco_igual_limite),
    .ultimo_nivel(ultimo_nivel), .fez_jogada(fez_jogada), .deu_timeout(deu_timeout),
    .zera_contador_nivel(zn[0]), .zera_contador_jogada(zj[0]), .zera_contador_score(zs[0]),
    .zeraR(zr[0]), .zera_timeout(zt[0]), .conta_nivel(cn[0]), .conta_jogada(cj[0]),
    .conta_score(cs[0]), .conta_timeout(ct[0]), .registraR(rr[0]), .dificuldade(dif[0]),
    .pronto(pr[0]), .acertou(ac[0]), .errou(er[0]), .timeout(to[0]), .db_estado(db[0])
  );

  unidade_controle_prova #(.TIMEOUT_EN(1'b0)) dut_nt (
    .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade_in(dificuldade_in),
    .jogada_igual_memoria(jogada_igual_memoria), .endereco_igual_limite(endereco_igual_limite),
    .ultimo_nivel(ultimo_nivel), .fez_jogada(fez_jogada), .deu_timeout(deu_timeout),
    .zera_contador_nivel(zn[1]), .zera_contador_jogada(zj[1]), .zera_contador_score(zs[1]),
    .zeraR(zr[1]), .zera_timeout(zt[1]), .conta_nivel(cn[1]), .conta_jogada(cj[1]),
    .conta_score(cs[1]), .conta_timeout(ct[1]), .registraR(rr[1]), .dificuldade(dif[1]),
    .pronto(pr[1]), .acertou(ac[1]), .errou(er[1]), .timeout(to[1]), .db_estado(db[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected strobes for a game phase, packed as
  // {zn,zj,zs,zr,zt,cn,cj,cs,ct,rr,pronto,acertou,errou,timeout}.
  function automatic logic [13:0] exp_out(input int st, input logic jim);
    case (st)
      1:  return 14'b11111_000000000;
      2:  return 14'b01011_000000000;
      3:  return 14'b00000_000100000;
      4:  return 14'b00001_000010000;
      5:  return {7'b0, jim, 6'b0};
      6:  return 14'b00000_010000000;
      7:  return 14'b00000_100000000;
      8:  return 14'b00000_000001100;
      9:  return 14'b00000_000001010;
      10: return 14'b00000_000001001;
      default: return 14'b0;
    endcase
  endfunction

  function automatic int next_phase(input int st, input bit en);
    case (st)
      0, 8, 9, 10: return iniciar ? 1 : st;
      1: return 2;
      2: return 3;
      3: begin
        if (fez_jogada) return 4;
        if (deu_timeout && en) return 10;
        return 3;
      end
      4: return 5;
      5: begin
        if (!jogada_igual_memoria) return 9;
        if (endereco_igual_limite) return ultimo_nivel ? 8 : 7;
        return 6;
      end
      6: return 3;
      7: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int i);
    if (!reset) begin
      m_st[i]  = 0;
      m_dif[i] = 1'b0;
    end else begin
      if ((m_st[i] == 0 || m_st[i] >= 8) && iniciar) m_dif[i] = dificuldade_in;
      m_st[i] = next_phase(m_st[i], i == 0);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.out%0d", tag, i),
            {18'b0, zn[i], zj[i], zs[i], zr[i], zt[i], cn[i], cj[i], cs[i], ct[i], rr[i],
             pr[i], ac[i], er[i], to[i]},
            {18'b0, exp_out(m_st[i], jogada_igual_memoria)});
      check($sformatf("%s.dif%0d", tag, i), {31'b0, dif[i]}, {31'b0, m_dif[i]});
      check($sformatf("%s.estado%0d", tag, i), {28'b0, db[i]}, m_st[i]);
    end
  endtask

  // One clock: check outputs mid-low-phase, advance DUT and model together.
  task automatic tick();
    #1;
    compare_all("cyc");
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) model_step(i);
    compare_all("rst_now");
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic set_in(input logic ini, input logic din, input logic jim,
                        input logic eil, input logic ul, input logic fez, input logic dt);
    iniciar = ini; dificuldade_in = din; jogada_igual_memoria = jim;
    endereco_igual_limite = eil; ultimo_nivel = ul; fez_jogada = fez; deu_timeout = dt;
  endtask

  task automatic expect_state(input string tag, input int code);
    check(tag, {28'b0, db[0]}, code);
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    m_st[0] = 0; m_st[1] = 0; m_dif[0] = 1'b0; m_dif[1] = 1'b0;
    @(negedge clock);
    tick();
    reset = 1'b1;
    tick();
    expect_state("idle_after_por", 0);

    // Reach ESPERA_JOGADA, then reset mid-game.
    set_in(1, 1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick(); tick();
    expect_state("in_espera", 3);
    do_reset();
    check("dif_cleared", {31'b0, dif[0]}, 0);
    tick(); tick();
    expect_state("hold_inicial", 0);

    // Correct play at level 0 -> next level.
    set_in(1, 0, 0, 0, 0, 0, 0); tick(); expect_state("seq_prep", 1);
    set_in(0, 0, 0, 0, 0, 0, 0); tick(); expect_state("seq_inicia", 2);
    tick(); expect_state("seq_espera", 3);
    set_in(0, 0, 0, 0, 0, 1, 0); tick(); expect_state("seq_registra", 4);
    set_in(0, 0, 1, 1, 0, 0, 0); tick(); expect_state("seq_comparacao", 5);
    check("score_pulse", {31'b0, cs[0]}, 1);
    tick(); expect_state("seq_prox_nivel", 7);
    check("score_low", {31'b0, cs[0]}, 0);
    check("nivel_pulse", {31'b0, cn[0]}, 1);
    tick(); expect_state("seq_inicia2", 2);

    // Correct play, not last of the level -> next play.
    set_in(0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 1, 0, 0, 0, 0); tick(); expect_state("jog_comparacao", 5);
    tick(); expect_state("jog_proxima", 6);
    check("jogada_pulse", {31'b0, cj[0]}, 1);
    tick(); expect_state("jog_espera", 3);

    // Wrong play -> FIM_ERROU, then restart.
    set_in(0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 1, 0, 0, 0); tick();
    check("score_on_miss", {31'b0, cs[0]}, 0);
    tick(); expect_state("errou", 9);
    check("errou_flag", {30'b0, pr[0], er[0]}, 3);
    set_in(1, 0, 0, 0, 0, 0, 0); tick(); expect_state("restart", 1);
    check("all_zera", {27'b0, zn[0], zj[0], zs[0], zr[0], zt[0]}, 5'h1f);

    // Timeout: instance 0 ends the game, instance 1 keeps waiting.
    set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick();
    expect_state("timeout", 10);
    check("timeout_flag", {31'b0, to[0]}, 1);
    check("no_timeout_en0", {28'b0, db[1]}, 3);
    tick();
    check("still_wait_en0", {28'b0, db[1]}, 3);

    // Press and timeout in the same cycle: the press wins.
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 1, 1); tick();
    expect_state("press_wins", 4);
    check("press_wins_en0", {28'b0, db[1]}, 4);

    // Difficulty latched at start, ignored mid-game; win on the last level.
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 1, 1, 1, 0, 0); tick();
    check("dif_held", {31'b0, dif[0]}, 1);
    tick(); expect_state("acertou", 8);
    check("acertou_flag", {30'b0, pr[0], ac[0]}, 3);
    set_in(1, 0, 0, 0, 0, 0, 0); tick();
    check("dif_relatch", {31'b0, dif[0]}, 0);

    // Randomized play against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
